mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF) and the execute-stage load/store unit (LSU).
- The exe stage's adr_v/adr/is_store/store_data/access_size outputs and its load_data input connect here, not to memory directly.
- Allows one outstanding transaction. The LSU has fixed priority over IF.
- A pipeline flush discards an in-flight fetch response without disturbing the memory bus protocol.

Parameters:
- XLEN, 32, data and address width.
- STARVE_LIMIT, 4, maximum consecutive LSU grants while IF waits. Used only with MEM_ARB_FAIRNESS_EN.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request; held with if_adr_i stable until if_gnt_o
- if_adr_i  in  XLEN  fetch address
- if_gnt_o  out  1  fetch request accepted by memory (1-cycle pulse)
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse)
- if_rdata_o  out  XLEN  fetch data
- lsu_req_i  in  1  load/store request; all lsu_* fields held stable until lsu_gnt_o
- lsu_adr_i  in  XLEN  access address
- lsu_we_i  in  1  1 = store
- lsu_wdata_i  in  XLEN  store data
- lsu_size_i  in  3  access size encoding, passed through unchanged
- lsu_gnt_o  out  1  LSU request accepted (1-cycle pulse)
- lsu_rvalid_o  out  1  load data / store acknowledge (1-cycle pulse)
- lsu_rdata_o  out  XLEN  load data
- flush_i  in  1  pipeline flush; kills the pending fetch response
- mem_req_o  out  1  memory request
- mem_adr_o  out  XLEN  memory address
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  XLEN  memory write data
- mem_size_o  out  3  memory access size
- mem_gnt_i  in  1  memory accepts the request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  XLEN  memory response data
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, owner=IF, drop=0, starve_cnt=0.
  - All registered outputs are 0: mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o.
  - Reset mid-transaction abandons it. No rvalid is issued for it.
- FSM states: IDLE, REQ, RSP.
- Arbitration point: IDLE, or RSP in the cycle mem_rvalid_i=1.
  - lsu_req_i=1: owner=LSU.
  - Else if_req_i=1: owner=IF.
  - Else: no arbitration result.
- When an owner is chosen:
  - Latch the owner's address, write enable, wdata and size into the mem_* output registers (IF: we=0, wdata=0, size=3'b010).
  - Set mem_req_o=1 and go to REQ.
  - The request is visible on mem_req_o one cycle after arbitration.
- Arbitration point with no request pending: go to (or stay in) IDLE; mem_req_o=0.
- REQ:
  - mem_req_o and the other mem_* outputs stay constant until mem_gnt_i=1.
  - In the mem_gnt_i cycle, pulse the owner's gnt_o, clear mem_req_o, go to RSP.
  - No timeout.
- RSP:
  - On mem_rvalid_i=1, the owner's rvalid_o=1 in the same cycle (combinational) and rdata_o=mem_rdata_i, unless owner=IF and a drop is active.
  - The non-owner's rvalid_o stays 0.
  - Back-to-back: arbitrate in the same cycle, which gives REQ the next cycle with no IDLE bubble.
- Minimum latency: request at cycle 0 → mem_req_o at cycle 1 → gnt at cycle ≥1 → rvalid at cycle ≥2.
- rdata_o values are don't-care when the matching rvalid_o=0. A store's rvalid is an acknowledge only.
- Flush:
  - flush_i=1 with owner=IF in REQ or RSP sets drop=1.
  - The bus request still completes normally; mem_req_o is never retracted.
  - The matching if_rvalid_o is suppressed.
  - flush_i in the same cycle as mem_rvalid_i also suppresses it.
  - drop clears when RSP is left.
  - flush_i has no effect when owner=LSU or in IDLE.
- Simultaneous lsu_req_i and if_req_i: LSU wins; IF stays pending.
- A requester whose gnt_o has pulsed may keep req high. That is treated as a new request at the next arbitration point.
- mem_gnt_i and mem_rvalid_i are ignored outside REQ and RSP respectively.

Optional Feature:
- Macro MEM_ARB_FAIRNESS_EN.
- Defined:
  - starve_cnt (width clog2(STARVE_LIMIT+1)) increments on each LSU arbitration win while if_req_i=1.
  - When starve_cnt==STARVE_LIMIT and if_req_i=1, the next arbitration grants IF regardless of lsu_req_i.
  - starve_cnt resets to 0 on any IF win, or at any arbitration with if_req_i=0.
- Undefined:
  - Strict LSU priority.
  - starve_cnt and STARVE_LIMIT have no effect; starve_cnt may be removed by synthesis.

Test Plan:
- Single fetch:
  - Stimulus: if_req_i=1, adr=0x100; mem_gnt_i=1 immediately; rvalid 1 cycle later with rdata=0xDEADBEEF.
  - Response: mem_req_o at cycle 1, if_gnt_o at cycle 1, if_rvalid_o=1 with if_rdata_o=0xDEADBEEF at cycle 2, busy_o=0 at cycle 3.
- Collision:
  - Stimulus: if_req_i and lsu_req_i (store, adr=0x200, wdata=0x55) both rise together.
  - Response: mem_we_o=1, mem_adr_o=0x200 first; then IF at 0x100 is requested the cycle after lsu_rvalid_o with no bubble.
- Stalled grant:
  - Stimulus: mem_gnt_i held 0 for 5 cycles during an LSU load.
  - Response: mem_req_o and mem_adr_o constant for all 5 cycles; lsu_gnt_o only in the gnt cycle.
- Flush:
  - Stimulus: flush_i pulsed in RSP for an IF transaction (also repeated with the flush in the same cycle as mem_rvalid_i).
  - Response: if_rvalid_o stays 0 in both cases; the next fetch completes normally.
- Reset mid-transaction:
  - Stimulus: reset asserted while in REQ.
  - Response: mem_req_o=0 and busy_o=0 immediately (asynchronous); no gnt_o or rvalid_o afterwards.
- Fairness (MEM_ARB_FAIRNESS_EN, STARVE_LIMIT=4):
  - Stimulus: lsu_req_i held high continuously with if_req_i=1.
  - Response: IF granted after exactly 4 LSU transactions.
  - Without the macro, IF is never granted under the same stimulus.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//    Shares the core's single memory port between instruction fetch (IF)
//    and the load/store unit (LSU). One transaction may be outstanding at a
//    time and the LSU has fixed priority over IF. A pipeline flush discards
//    an in-flight fetch response while letting the bus handshake finish.
//
//    Optional build macro: MEM_ARB_FAIRNESS_EN
//       When defined, IF is forced through after STARVE_LIMIT consecutive
//       LSU wins while IF is waiting. When undefined, strict LSU priority.
//
// Ports
//    clk, reset             core clock, asynchronous active-high reset
//    if_req_i/if_adr_i      fetch request and address (held until if_gnt_o)
//    if_gnt_o               fetch accepted by memory (1-cycle pulse)
//    if_rvalid_o/if_rdata_o fetch response (1-cycle pulse, combinational)
//    lsu_req_i ... size_i   load/store request fields (held until lsu_gnt_o)
//    lsu_gnt_o              load/store accepted (1-cycle pulse)
//    lsu_rvalid_o/rdata_o   load data or store acknowledge
//    flush_i                kills the pending fetch response
//    mem_*_o                registered memory request towards the bus
//    mem_gnt_i/rvalid_i/rdata_i  memory handshake and response
//    busy_o                 arbiter is not idle
module mem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_adr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [XLEN-1:0] if_rdata_o,
   input  logic            lsu_req_i,
   input  logic [XLEN-1:0] lsu_adr_i,
   input  logic            lsu_we_i,
   input  logic [XLEN-1:0] lsu_wdata_i,
   input  logic [2:0]      lsu_size_i,
   output logic            lsu_gnt_o,
   output logic            lsu_rvalid_o,
   output logic [XLEN-1:0] lsu_rdata_o,
   input  logic            flush_i,
   output logic            mem_req_o,
   output logic [XLEN-1:0] mem_adr_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [2:0]      mem_size_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            busy_o
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
   typedef enum logic {OWN_IF, OWN_LSU} owner_t;

   state_t          state_q, state_d;
   owner_t          owner_q, owner_d;
   logic            drop_q, drop_d;
   logic [CW-1:0]   starve_q, starve_d;
   logic            req_d, we_d;
   logic [XLEN-1:0] adr_d, wdata_d;
   logic [2:0]      size_d;
   logic            arb_pt, force_if, pick_if, pick_lsu;

   // A new owner may be chosen when idle, or in the response cycle of the
   // current transaction so back-to-back requests see no idle bubble.
   // force_if is the fairness override; without the macro it never fires.
   always_comb begin
      arb_pt = (state_q == IDLE) || ((state_q == RSP) && mem_rvalid_i);
`ifdef MEM_ARB_FAIRNESS_EN
      force_if = if_req_i && (starve_q == CW'(STARVE_LIMIT));
`else
      force_if = 1'b0;
`endif
      pick_if  = if_req_i && (force_if || !lsu_req_i);
      pick_lsu = lsu_req_i && !pick_if;
   end

   // Next-state logic. The mem_* registers hold their value unless an owner
   // is chosen, so the request stays stable while waiting for mem_gnt_i.
   // drop records a flush against an in-flight fetch; it is cleared as soon
   // as the response cycle is left so it never leaks into the next fetch.
   // The starvation counter saturates so it stays bounded without fairness.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      drop_d   = drop_q;
      starve_d = starve_q;
      req_d    = mem_req_o;
      adr_d    = mem_adr_o;
      we_d     = mem_we_o;
      wdata_d  = mem_wdata_o;
      size_d   = mem_size_o;

      if ((state_q != IDLE) && (owner_q == OWN_IF) && flush_i) begin
         drop_d = 1'b1;
      end

      if ((state_q == REQ) && mem_gnt_i) begin
         req_d   = 1'b0;
         state_d = RSP;
      end

      if ((state_q == RSP) && mem_rvalid_i) begin
         drop_d = 1'b0;
      end

      if (arb_pt) begin
         if (pick_lsu) begin
            owner_d = OWN_LSU;
            state_d = REQ;
            req_d   = 1'b1;
            adr_d   = lsu_adr_i;
            we_d    = lsu_we_i;
            wdata_d = lsu_wdata_i;
            size_d  = lsu_size_i;
         end else if (pick_if) begin
            owner_d = OWN_IF;
            state_d = REQ;
            req_d   = 1'b1;
            adr_d   = if_adr_i;
            we_d    = 1'b0;
            wdata_d = '0;
            size_d  = 3'b010;
         end else begin
            state_d = IDLE;
            req_d   = 1'b0;
         end

         if (pick_lsu && if_req_i) begin
            if (starve_q != CW'(STARVE_LIMIT)) begin
               starve_d = starve_q + CW'(1);
            end
         end else begin
            starve_d = '0;
         end
      end
   end

   // State and memory-request registers; reset abandons any transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         drop_q      <= 1'b0;
         starve_q    <= '0;
         mem_req_o   <= 1'b0;
         mem_adr_o   <= '0;
         mem_we_o    <= 1'b0;
         mem_wdata_o <= '0;
         mem_size_o  <= 3'b000;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         drop_q      <= drop_d;
         starve_q    <= starve_d;
         mem_req_o   <= req_d;
         mem_adr_o   <= adr_d;
         mem_we_o    <= we_d;
         mem_wdata_o <= wdata_d;
         mem_size_o  <= size_d;
      end
   end

   // Grants and responses are steered to the current owner combinationally.
   // A fetch response is suppressed by an earlier flush or a flush arriving
   // in the response cycle itself.
   always_comb begin
      if_gnt_o     = (state_q == REQ) && mem_gnt_i && (owner_q == OWN_IF);
      lsu_gnt_o    = (state_q == REQ) && mem_gnt_i && (owner_q == OWN_LSU);
      if_rvalid_o  = (state_q == RSP) && mem_rvalid_i && (owner_q == OWN_IF)
                     && !drop_q && !flush_i;
      lsu_rvalid_o = (state_q == RSP) && mem_rvalid_i && (owner_q == OWN_LSU);
      if_rdata_o   = mem_rdata_i;
      lsu_rdata_o  = mem_rdata_i;
      busy_o       = (state_q != IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//    Directed bench for mem_port_arbiter. Each scenario task drives the
//    requesters and plays the memory side by hand, then compares outputs
//    against hand-computed values at the falling clock edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req_i, lsu_req_i, lsu_we_i, flush_i;
   logic [31:0] if_adr_i, lsu_adr_i, lsu_wdata_i, mem_rdata_i;
   logic [2:0]  lsu_size_i;
   logic        mem_gnt_i, mem_rvalid_i;
   logic        if_gnt_o, if_rvalid_o, lsu_gnt_o, lsu_rvalid_o;
   logic [31:0] if_rdata_o, lsu_rdata_o;
   logic        mem_req_o, mem_we_o, busy_o;
   logic [31:0] mem_adr_o, mem_wdata_o;
   logic [2:0]  mem_size_o;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .lsu_req_i(lsu_req_i), .lsu_adr_i(lsu_adr_i), .lsu_we_i(lsu_we_i),
      .lsu_wdata_i(lsu_wdata_i), .lsu_size_i(lsu_size_i), .lsu_gnt_o(lsu_gnt_o),
      .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
      .flush_i(flush_i),
      .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
      .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus();
      if_req_i = 0; if_adr_i = '0; lsu_req_i = 0; lsu_adr_i = '0; lsu_we_i = 0;
      lsu_wdata_i = '0; lsu_size_i = 3'b000; flush_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if ({mem_req_o, mem_we_o, mem_size_o, busy_o} !== 6'b0) begin
         failures++; $display("[TB] FAIL reset_ctrl got=%b exp=000000", {mem_req_o, mem_we_o, mem_size_o, busy_o}); end
      checks++; if ({mem_adr_o, mem_wdata_o} !== 64'h0) begin
         failures++; $display("[TB] FAIL reset_data got=%h exp=0", {mem_adr_o, mem_wdata_o}); end
      checks++; if ({if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o} !== 4'b0) begin
         failures++; $display("[TB] FAIL reset_hs got=%b exp=0000", {if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o}); end
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_single_fetch();
      cyc(); if_req_i = 1; if_adr_i = 32'h100;
      @(negedge clk);
      checks++; if ({mem_req_o, busy_o} !== 2'b00) begin
         failures++; $display("[TB] FAIL fetch_c0 got=%b exp=00", {mem_req_o, busy_o}); end
      cyc(); mem_gnt_i = 1;
      @(negedge clk);
      checks++; if ({mem_req_o, mem_adr_o, mem_we_o, mem_size_o} !== {1'b1, 32'h100, 1'b0, 3'b010}) begin
         failures++; $display("[TB] FAIL fetch_req got=%h exp=%h", {mem_req_o, mem_adr_o, mem_we_o, mem_size_o}, {1'b1, 32'h100, 1'b0, 3'b010}); end
      checks++; if ({if_gnt_o, lsu_gnt_o} !== 2'b10) begin
         failures++; $display("[TB] FAIL fetch_gnt got=%b exp=10", {if_gnt_o, lsu_gnt_o}); end
      cyc(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if ({mem_req_o, if_rvalid_o, lsu_rvalid_o} !== 3'b010) begin
         failures++; $display("[TB] FAIL fetch_rvalid got=%b exp=010", {mem_req_o, if_rvalid_o, lsu_rvalid_o}); end
      checks++; if (if_rdata_o !== 32'hDEADBEEF) begin
         failures++; $display("[TB] FAIL fetch_rdata got=%h exp=deadbeef", if_rdata_o); end
      cyc(); mem_rvalid_i = 0;
      @(negedge clk);
      checks++; if ({busy_o, if_rvalid_o} !== 2'b00) begin
         failures++; $display("[TB] FAIL fetch_idle got=%b exp=00", {busy_o, if_rvalid_o}); end
   endtask

   task automatic test_collision();
      cyc(); if_req_i = 1; if_adr_i = 32'h100;
      lsu_req_i = 1; lsu_we_i = 1; lsu_adr_i = 32'h200; lsu_wdata_i = 32'h55; lsu_size_i = 3'b010;
      cyc(); mem_gnt_i = 1;
      @(negedge clk);
      checks++; if ({mem_req_o, mem_we_o, mem_adr_o, mem_wdata_o} !== {1'b1, 1'b1, 32'h200, 32'h55}) begin
         failures++; $display("[TB] FAIL coll_lsu_first got=%h exp=%h", {mem_req_o, mem_we_o, mem_adr_o, mem_wdata_o}, {1'b1, 1'b1, 32'h200, 32'h55}); end
      checks++; if ({lsu_gnt_o, if_gnt_o} !== 2'b10) begin
         failures++; $display("[TB] FAIL coll_gnt got=%b exp=10", {lsu_gnt_o, if_gnt_o}); end
      cyc(); lsu_req_i = 0; lsu_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0;
      @(negedge clk);
      checks++; if ({lsu_rvalid_o, if_rvalid_o} !== 2'b10) begin
         failures++; $display("[TB] FAIL coll_lsu_ack got=%b exp=10", {lsu_rvalid_o, if_rvalid_o}); end
      cyc(); mem_rvalid_i = 0; mem_gnt_i = 1;
      @(negedge clk);
      checks++; if ({busy_o, mem_req_o, mem_we_o, mem_adr_o, mem_wdata_o} !== {1'b1, 1'b1, 1'b0, 32'h100, 32'h0}) begin
         failures++; $display("[TB] FAIL coll_if_next got=%h exp=%h", {busy_o, mem_req_o, mem_we_o, mem_adr_o, mem_wdata_o}, {1'b1, 1'b1, 1'b0, 32'h100, 32'h0}); end
      checks++; if (if_gnt_o !== 1'b1) begin
         failures++; $display("[TB] FAIL coll_if_gnt got=%b exp=1", if_gnt_o); end
      cyc(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1234;
      @(negedge clk);
      checks++; if ({if_rvalid_o, lsu_rvalid_o, if_rdata_o} !== {2'b10, 32'h1234}) begin
         failures++; $display("[TB] FAIL coll_if_rsp got=%h exp=%h", {if_rvalid_o, lsu_rvalid_o, if_rdata_o}, {2'b10, 32'h1234}); end
      cyc(); mem_rvalid_i = 0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin
         failures++; $display("[TB] FAIL coll_idle got=%b exp=0", busy_o); end
   endtask

   task automatic test_stalled_grant();
      cyc(); lsu_req_i = 1; lsu_we_i = 0; lsu_adr_i = 32'h300; lsu_size_i = 3'b001;
      for (int i = 0; i < 5; i++) begin
         cyc();
         @(negedge clk);
         checks++; if ({mem_req_o, mem_adr_o, mem_size_o, lsu_gnt_o} !== {1'b1, 32'h300, 3'b001, 1'b0}) begin
            failures++; $display("[TB] FAIL stall_hold[%0d] got=%h exp=%h", i, {mem_req_o, mem_adr_o, mem_size_o, lsu_gnt_o}, {1'b1, 32'h300, 3'b001, 1'b0}); end
      end
      cyc(); mem_gnt_i = 1;
      @(negedge clk);
      checks++; if ({lsu_gnt_o, mem_req_o} !== 2'b11) begin
         failures++; $display("[TB] FAIL stall_gnt got=%b exp=11", {lsu_gnt_o, mem_req_o}); end
      cyc(); lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE;
      @(negedge clk);
      checks++; if ({lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o} !== {2'b01, 32'hCAFE}) begin
         failures++; $display("[TB] FAIL stall_rsp got=%h exp=%h", {lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o}, {2'b01, 32'hCAFE}); end
      cyc(); mem_rvalid_i = 0;
   endtask

   task automatic test_flush();
      // flush while waiting for the response
      cyc(); if_req_i = 1; if_adr_i = 32'h400;
      cyc(); mem_gnt_i = 1;
      cyc(); if_req_i = 0; mem_gnt_i = 0; flush_i = 1;
      @(negedge clk);
      checks++; if (if_rvalid_o !== 1'b0) begin
         failures++; $display("[TB] FAIL flush_a_early got=%b exp=0", if_rvalid_o); end
      cyc(); flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD;
      @(negedge clk);
      checks++; if ({if_rvalid_o, busy_o} !== 2'b01) begin
         failures++; $display("[TB] FAIL flush_a_drop got=%b exp=01", {if_rvalid_o, busy_o}); end
      cyc(); mem_rvalid_i = 0;
      // flush in the same cycle as the response
      cyc(); if_req_i = 1; if_adr_i = 32'h404;
      cyc(); mem_gnt_i = 1;
      cyc(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; flush_i = 1; mem_rdata_i = 32'hBAD2;
      @(negedge clk);
      checks++; if (if_rvalid_o !== 1'b0) begin
         failures++; $display("[TB] FAIL flush_b_drop got=%b exp=0", if_rvalid_o); end
      cyc(); mem_rvalid_i = 0; flush_i = 0;
      // following fetch must complete normally
      cyc(); if_req_i = 1; if_adr_i = 32'h408;
      cyc(); mem_gnt_i = 1;
      @(negedge clk);
      checks++; if ({if_gnt_o, mem_adr_o} !== {1'b1, 32'h408}) begin
         failures++; $display("[TB] FAIL flush_next_gnt got=%h exp=%h", {if_gnt_o, mem_adr_o}, {1'b1, 32'h408}); end
      cyc(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h600D;
      @(negedge clk);
      checks++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h600D}) begin
         failures++; $display("[TB] FAIL flush_next_rsp got=%h exp=%h", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h600D}); end
      cyc(); mem_rvalid_i = 0;
      // flush does not touch an LSU transaction
      cyc(); lsu_req_i = 1; lsu_adr_i = 32'h800;
      cyc(); mem_gnt_i = 1;
      cyc(); lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; flush_i = 1; mem_rdata_i = 32'h99;
      @(negedge clk);
      checks++; if ({lsu_rvalid_o, lsu_rdata_o} !== {1'b1, 32'h99}) begin
         failures++; $display("[TB] FAIL flush_lsu got=%h exp=%h", {lsu_rvalid_o, lsu_rdata_o}, {1'b1, 32'h99}); end
      cyc(); mem_rvalid_i = 0; flush_i = 0;
   endtask

   task automatic test_reset_mid();
      cyc(); lsu_req_i = 1; lsu_we_i = 1; lsu_adr_i = 32'h500; lsu_wdata_i = 32'h77;
      cyc();
      @(negedge clk);
      checks++; if ({mem_req_o, busy_o} !== 2'b11) begin
         failures++; $display("[TB] FAIL rstmid_req got=%b exp=11", {mem_req_o, busy_o}); end
      #2 reset = 1'b1;
      #1;
      checks++; if ({mem_req_o, busy_o, mem_adr_o} !== {2'b00, 32'h0}) begin
         failures++; $display("[TB] FAIL rstmid_async got=%h exp=0", {mem_req_o, busy_o, mem_adr_o}); end
      applyStimulus();
      cyc(); reset = 1'b0;
      mem_gnt_i = 1; mem_rvalid_i = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if ({if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o, mem_req_o} !== 5'b0) begin
            failures++; $display("[TB] FAIL rstmid_quiet[%0d] got=%b exp=00000", i, {if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o, mem_req_o}); end
         cyc();
      end
      mem_gnt_i = 0; mem_rvalid_i = 0;
   endtask

   task automatic test_fairness();
      int lsu_cnt = 0;
      bit if_seen = 0;
      int exp_lsu;
      bit exp_if;
`ifdef MEM_ARB_FAIRNESS_EN
      exp_lsu = 4;  exp_if = 1'b1;
`else
      exp_lsu = 15; exp_if = 1'b0;
`endif
      cyc(); lsu_req_i = 1; lsu_we_i = 0; lsu_adr_i = 32'h600;
      if_req_i = 1; if_adr_i = 32'h700; mem_gnt_i = 1; mem_rvalid_i = 1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!if_seen && lsu_gnt_o) lsu_cnt++;
         if (if_gnt_o) if_seen = 1'b1;
      end
      checks++; if (if_seen !== exp_if) begin
         failures++; $display("[TB] FAIL fair_if_gnt got=%b exp=%b", if_seen, exp_if); end
      checks++; if (lsu_cnt !== exp_lsu) begin
         failures++; $display("[TB] FAIL fair_lsu_count got=%0d exp=%0d", lsu_cnt, exp_lsu); end
      cyc(); lsu_req_i = 0; if_req_i = 0;
      repeat (3) cyc();
      mem_gnt_i = 0; mem_rvalid_i = 0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin
         failures++; $display("[TB] FAIL fair_drain got=%b exp=0", busy_o); end
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_single_fetch();
      test_collision();
      test_stalled_grant();
      test_flush();
      test_reset_mid();
      test_fairness();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
